// File: rtl/fifo_stream_drain.sv
// Purpose: turns the synchronous FIFO's pull port into a valid/ready push stream, with run/drain control.
// Latency: 2 cycles from the first fifo_rd_en to m_valid (issue, capture, visible); 1 beat/cycle sustained.
// Backpressure: m_ready low holds m_data; reads are throttled so buffered + in-flight words never exceed BUF_DEPTH.
// Optional statistics counters (beat_count, stall_count) are built when FIFO_DRAIN_STATS_EN is defined.
module fifo_stream_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy,
`ifdef FIFO_DRAIN_STATS_EN
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  stall_count,
`endif
    output logic                  drain_done
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int PND_W = OCC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    drain_done_q, drain_done_d;
    logic [OCC_W-1:0]        occ_q, occ_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic                    inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0]   mem_q [BUF_DEPTH];

    logic                    pop;
    logic                    capture;
    logic [PND_W-1:0]        pending;

    // Read issue: buffered + in-flight words after this cycle's pop must leave room for one more.
    // Gating on enable stops fetching in the very cycle enable is seen low.
    always_comb begin
        pop        = (occ_q != '0) && m_ready;
        capture    = inflight_q;
        pending    = PND_W'(occ_q) + PND_W'(inflight_q) - PND_W'(pop);
        fifo_rd_en = (state_q == RUN) && enable && !fifo_empty
                     && (pending < PND_W'(BUF_DEPTH));
    end

    // Next-state of the skid buffer bookkeeping; a capture and pop together leave occupancy unchanged.
    always_comb begin
        occ_d      = occ_q + OCC_W'(capture) - OCC_W'(pop);
        wr_ptr_d   = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        inflight_d = fifo_rd_en;
    end

    // Buffer state and storage; reset drops buffered and in-flight words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            if (capture) begin
                mem_q[wr_ptr_q] <= fifo_data_out;
            end
        end
    end

    // Run/drain control; drain completes once nothing is buffered or in flight after this cycle's pop.
    always_comb begin
        state_d      = state_q;
        drain_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable) begin
                    state_d = RUN;
                end else if (!inflight_q &&
                             ((occ_q == '0) || ((occ_q == OCC_W'(1)) && pop))) begin
                    state_d      = IDLE;
                    drain_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM register with registered completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            drain_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            drain_done_q <= drain_done_d;
        end
    end

    // Stream outputs come straight from buffer state.
    always_comb begin
        m_valid    = (occ_q != '0);
        m_data     = mem_q[rd_ptr_q];
        busy       = (occ_q != '0) || inflight_q;
        drain_done = drain_done_q;
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                 run_start;

    // Saturating beat/stall counters, cleared when a new run begins.
    always_comb begin
        run_start     = (state_q == IDLE) && (state_d == RUN);
        beat_count_d  = beat_count_q;
        stall_count_d = stall_count_q;
        if (run_start) begin
            beat_count_d  = '0;
            stall_count_d = '0;
        end else begin
            if (pop && (beat_count_q != '1)) begin
                beat_count_d = beat_count_q + CNT_WIDTH'(1);
            end
            if (m_valid && !m_ready && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            beat_count_q  <= beat_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Counter outputs.
    always_comb begin
        beat_count  = beat_count_q;
        stall_count = stall_count_q;
    end
`endif

endmodule

// File: tb/tb_fifo_stream_drain.sv
module tb_fifo_stream_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        fifo_rd_en;
    logic [15:0] fifo_data_out;
    logic        fifo_empty;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        busy;
    logic        drain_done;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] beat_count;
    logic [31:0] stall_count;
`endif

    fifo_stream_drain #(
        .DATA_WIDTH(16),
        .BUF_DEPTH (2),
        .CNT_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_data_out(fifo_data_out),
        .fifo_empty   (fifo_empty),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .busy         (busy),
`ifdef FIFO_DRAIN_STATS_EN
        .beat_count   (beat_count),
        .stall_count  (stall_count),
`endif
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    // FIFO model contents and scoreboard of words expected on the stream
    logic [15:0] fifo_q [$];
    logic [15:0] exp_q  [$];

    int tests = 0;
    int fails = 0;
    int n_reads, n_pops, n_drain, max_pend;
    logic rd_pend;

    typedef struct {
        logic en;
        logic rdy;
        logic exp_rd;
        logic exp_vld;
        logic exp_busy;
    } vec_t;
    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_words(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            fifo_q.push_back(16'(first + i));
            exp_q.push_back(16'(first + i));
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // Observe the DUT mid-cycle: FIFO contract, scoreboard, counters
    task automatic sample();
        @(negedge clk);
        rd_pend = fifo_rd_en;
        if (fifo_rd_en && fifo_empty) begin
            check("rd_while_empty", 32'(fifo_rd_en), 32'd0);
            rd_pend = 1'b0;
        end
        if (rd_pend) n_reads++;
        if (drain_done) n_drain++;
        if (m_valid && m_ready) begin
            n_pops++;
            if (exp_q.size() == 0) check("unexpected_beat", 32'(m_data), 32'hdead);
            else check("beat_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        if (n_reads - n_pops > max_pend) max_pend = n_reads - n_pops;
    endtask

    // Clock edge, then the FIFO model answers the read accepted in the previous cycle
    task automatic advance();
        @(posedge clk);
        #1;
        if (rd_pend) fifo_data_out = fifo_q.pop_front();
        rd_pend    = 1'b0;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            advance();
        end
    endtask

    task automatic clr_counts();
        n_reads = 0; n_pops = 0; n_drain = 0; max_pend = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_vld;
        int   stalls;

        rst_n = 1'b0; enable = 1'b0; m_ready = 1'b1;
        fifo_empty = 1'b1; fifo_data_out = '0; rd_pend = 1'b0;
        clr_counts();

        // Streaming with the FIFO preloaded: per-cycle rd_en / m_valid / busy
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // IDLE, enable seen
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};  // first read
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};  // in flight
        for (int i = 3; i <= 8; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};  // FIFO empty
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drain_done", 32'(drain_done), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        push_words(1, 8);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);
        check("idle_no_read", 32'(n_reads), 32'd0);

        // Table-driven 8-beat stream
        clr_counts();
        for (int i = 0; i < 12; i++) begin
            enable  = vecs[i].en;
            m_ready = vecs[i].rdy;
            sample();
            check($sformatf("tbl%0d_rd_en", i), 32'(fifo_rd_en), 32'(vecs[i].exp_rd));
            check($sformatf("tbl%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].exp_vld));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            advance();
        end
        check("stream_beats", 32'(n_pops), 32'd8);
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Back-pressure: exactly BUF_DEPTH reads, head word held
        clr_counts();
        m_ready = 1'b0;
        push_words(1, 4);
        for (int i = 0; i < 10; i++) begin
            sample();
            if (i >= 2) check("hold_m_data", 32'(m_data), 32'h0001);
            if (i >= 2) check("hold_m_valid", 32'(m_valid), 32'd1);
            advance();
        end
        check("bp_reads", 32'(n_reads), 32'd2);
        m_ready = 1'b1;
        cycles(12);
        check("bp_beats", 32'(n_pops), 32'd4);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        check("bp_busy", 32'(busy), 32'd0);

        // Alternating ready with 16 words
        clr_counts();
        push_words(16'h0100, 16);
        for (int i = 0; i < 60; i++) begin
            m_ready = i[0];
            sample();
            advance();
        end
        m_ready = 1'b1;
        check("alt_beats", 32'(n_pops), 32'd16);
        check("alt_sb_empty", 32'(exp_q.size()), 32'd0);
        check("alt_max_occ_le2", 32'(max_pend <= 2), 32'd1);

        // Drain with one beat buffered and one read in flight
        push_words(16'h0200, 6);
        cycles(5);
        clr_counts();
        enable = 1'b0;
        cycles(20);
        check("drain_reads", 32'(n_reads), 32'd0);
        check("drain_beats", 32'(n_pops), 32'd2);
        check("drain_pulses", 32'(n_drain), 32'd1);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_left", 32'(exp_q.size()), 32'd1);

        // Asynchronous reset with a full buffer
        push_words(16'h0300, 4);
        m_ready = 1'b0;
        enable  = 1'b1;
        cycles(6);
        check("pre_rst_m_valid", 32'(m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", 32'(m_valid), 32'd0);
        check("arst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        exp_q = fifo_q;
        cycles(2);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        clr_counts();
        cycles(15);
        check("post_rst_beats", 32'(n_pops), 32'd3);
        check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_DRAIN_STATS_EN
        // Statistics: 8 beats, 3 stall cycles, then clear on a new run
        enable = 1'b0;
        cycles(10);
        push_words(16'h0400, 8);
        enable = 1'b1; m_ready = 1'b1;
        seen_vld = 1'b0; stalls = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (m_valid) seen_vld = 1'b1;
            advance();
            if (seen_vld && stalls < 3) begin
                m_ready = 1'b0;
                stalls++;
            end else begin
                m_ready = 1'b1;
            end
        end
        check("stats_beat_count", beat_count, 32'd8);
        check("stats_stall_count", stall_count, 32'd3);
        enable = 1'b0;
        cycles(10);
        enable = 1'b1;
        cycles(2);
        check("stats_clr_beat", beat_count, 32'd0);
        check("stats_clr_stall", stall_count, 32'd0);
`else
        seen_vld = 1'b0;
        stalls   = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
